// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch front end for the 5-stage core.
//
// Owns the fetch PC, drives the word-indexed instruction memory read port (combinational read)
// and queues {pc, instr} pairs in a small in-order buffer. The IF/ID stage consumes the buffer
// head through a valid/ready handshake. EX-stage redirects flush the buffer and reload the PC;
// a level halt request stops new fetches while the buffer keeps draining.
//
// Ports:
//   clk            core clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   imem_addr      byte address to instruction memory (always the fetch PC)
//   imem_rdata     instruction word read combinationally at imem_addr
//   imem_en        high in cycles where imem_rdata is captured into the buffer
//   redirect_valid EX-stage taken branch/jump this cycle
//   redirect_pc    redirect target byte address (low two bits ignored)
//   halt_req       level; no new fetches are issued while high
//   out_valid      buffer head entry valid
//   out_ready      IF/ID accepts the head entry
//   out_pc         byte PC of the head entry
//   out_instr      instruction word of the head entry
//   fetch_fault    out-of-range fetch flag (sticky until reset)
//
// Optional feature: define IMEM_BOUNDS_CHECK_EN to enable the instruction memory bounds check.
// A fetch attempt at a word index >= IMEM_DEPTH then moves the sequencer into a terminal fault
// state that only reset leaves. Without the macro the PC wraps freely and fetch_fault is 0.
//
// Parameters:
//   RESET_PC    fetch address loaded on reset
//   IMEM_DEPTH  instruction memory depth in words (bounds check only)
//   BUF_DEPTH   fetch buffer entries; power of two, >= 2

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        imem_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_fault
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntZero = CntW'(0);
  localparam logic [CntW-1:0] CntFull = CntW'(BUF_DEPTH);

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit BoundsCheck = 1'b1;
`else
  localparam bit BoundsCheck = 1'b0;
`endif

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalted,
    StFault
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       out_pc_q, out_pc_d;
  logic [31:0]       out_instr_q, out_instr_d;

  // Buffer storage carries no reset; validity is tracked by count_q alone.
  logic [31:0]       buf_pc_q    [BUF_DEPTH];
  logic [31:0]       buf_instr_q [BUF_DEPTH];

  logic              pop;
  logic              redirect_take;
  logic              issue_try;
  logic              out_of_range;
  logic              fault_trip;
  logic              push;
  logic [CntW-1:0]   remain;

  // ---------------------------------------------------------------------------------------------
  // Handshake, issue and redirect decisions
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    pop           = out_valid && out_ready;
    redirect_take = redirect_valid && ((state_q == StRun) || (state_q == StHalted));
    // A full buffer can still accept a fetch when the head leaves in the same cycle.
    issue_try     = (state_q == StRun) && !halt_req && !redirect_valid &&
                    ((count_q != CntFull) || pop);
    out_of_range  = {2'b00, fetch_pc_q[31:2]} >= IMEM_DEPTH;
    fault_trip    = BoundsCheck && issue_try && out_of_range;
    push          = issue_try && !fault_trip;
  end

  // ---------------------------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:   state_d = halt_req ? StHalted : StRun;
      StRun: begin
        if (fault_trip) begin
          state_d = StFault;
        end else if (halt_req) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (!halt_req) begin
          state_d = StRun;
        end
      end
      StFault:  state_d = StFault;
      default:  state_d = StBoot;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Fetch PC, buffer pointers and head output registers
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    // Entries still queued after this cycle's pop, before this cycle's push.
    remain      = count_q - (pop ? CntOne : CntZero);

    if (redirect_take) begin
      // Flush wins over everything; the head registers keep their last values.
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        tail_d     = tail_q + PtrOne;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + PtrOne;
      end
      count_d = remain + (push ? CntOne : CntZero);

      // The next head is either an older queued entry or, when nothing else remains, the word
      // being captured right now (which bypasses the storage array).
      if (remain != CntZero) begin
        out_pc_d    = buf_pc_q[head_d];
        out_instr_d = buf_instr_q[head_d];
      end else if (push) begin
        out_pc_d    = fetch_pc_q;
        out_instr_d = imem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StBoot;
      fetch_pc_q  <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      buf_pc_q[tail_q]    <= fetch_pc_q;
      buf_instr_q[tail_q] <= imem_rdata;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign imem_addr = fetch_pc_q;
  assign imem_en   = push && !reset;
  assign out_valid = (count_q != CntZero);
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

`ifdef IMEM_BOUNDS_CHECK_EN
  // The fault state is terminal until reset, so the flag is sticky by construction.
  assign fetch_fault = (state_q == StFault);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. A queue-based reference model tracks the expected
// buffer contents, fetch PC and control mode; every cycle the DUT outputs are compared against
// it. Directed scenarios come first, followed by a randomized stretch.

module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned BUF_DEPTH  = 2;

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit Bounds = 1'b1;
`else
  localparam bit Bounds = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_en;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;

  always #5 clk = ~clk;

  // Memory content: word i holds 0x1000_0000 + i.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_sequencer #(
    .RESET_PC   (RESET_PC),
    .IMEM_DEPTH (IMEM_DEPTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_en        (imem_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_fault    (fetch_fault)
  );

  // Reference model
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam int ModeBoot   = 0;
  localparam int ModeRun    = 1;
  localparam int ModeHalted = 2;
  localparam int ModeFault  = 3;

  entry_t      m_q[$];
  int          m_mode = ModeBoot;
  logic [31:0] m_pc = '0;
  bit          m_known = 1'b0;
  bit          m_after_reset = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit h,
                      input bit rdy);
    bit att;
    bit oob;
    bit pop;
    @(negedge clk);
    reset          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = h;
    out_ready      = rdy;
    #1;
    pop = (m_q.size() != 0) && rdy;
    att = (m_mode == ModeRun) && !h && !rv && ((m_q.size() < BUF_DEPTH) || pop);
    oob = Bounds && ((m_pc >> 2) >= IMEM_DEPTH);
    if (m_known) begin
      check1("out_valid", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check32("out_pc", out_pc, m_q[0].pc);
        check32("out_instr", out_instr, m_q[0].instr);
      end else if (m_after_reset) begin
        check32("out_pc_reset", out_pc, 32'h0);
        check32("out_instr_reset", out_instr, 32'h0);
      end
      check32("imem_addr", imem_addr, m_pc);
      check1("imem_en", imem_en, !r && att && !oob);
      check1("fetch_fault", fetch_fault, m_mode == ModeFault);
    end
    @(posedge clk);
    if (r) begin
      m_mode        = ModeBoot;
      m_pc          = RESET_PC;
      m_q.delete();
      m_known       = 1'b1;
      m_after_reset = 1'b1;
    end else if (m_known) begin
      case (m_mode)
        ModeBoot: m_mode = h ? ModeHalted : ModeRun;
        ModeRun, ModeHalted: begin
          if (rv) begin
            m_q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
          end else begin
            if (pop) void'(m_q.pop_front());
            if (att && oob) begin
              m_mode = ModeFault;
            end else if (att) begin
              m_q.push_back({m_pc, mem_word(m_pc)});
              m_pc          = m_pc + 32'd4;
              m_after_reset = 1'b0;
            end
          end
          if (m_mode == ModeRun && h) m_mode = ModeHalted;
          else if (m_mode == ModeHalted && !h) m_mode = ModeRun;
        end
        default: begin
          if (pop) void'(m_q.pop_front());
        end
      endcase
    end
  endtask

  task automatic run_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  initial begin
    // Reset and boot, then a steady stream from address 0.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    run_cycles(8, 1'b1);

    // Back-pressure: buffer fills, fetch freezes, then resumes without gap or duplicate.
    run_cycles(5, 1'b0);
    run_cycles(4, 1'b1);

    // Redirect with two entries buffered.
    run_cycles(2, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0042, 1'b0, 1'b0);
    run_cycles(5, 1'b1);

    // Halt for three cycles while draining, then resume at the held PC.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    run_cycles(5, 1'b1);

    // Reset mid-stream with a full buffer.
    run_cycles(2, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    run_cycles(6, 1'b1);

    // Top of the instruction memory: 0xF8, 0xFC, then 0x100 faults or continues.
    step(1'b0, 1'b1, 32'h0000_00F8, 1'b0, 1'b1);
    run_cycles(6, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b1);
    run_cycles(3, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    run_cycles(3, 1'b1);

    // PC wrap at the top of the address space (only meaningful without the bounds check).
    if (!Bounds) begin
      step(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b0, 1'b1);
      run_cycles(5, 1'b1);
    end

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      bit          r;
      bit          rv;
      bit          h;
      bit          rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) < 2);
      rv  = ($urandom_range(0, 99) < 6);
      h   = ($urandom_range(0, 99) < 12);
      rdy = ($urandom_range(0, 99) < 70);
      rpc = Bounds ? 32'($urandom_range(0, 32'h120)) : $urandom;
      step(r, rv, rpc, h, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Drives the word-indexed instruction memory read port (combinational read, byte PC, index = pc[31:2]) and delivers {pc, instr} pairs to the IF/ID stage through a valid/ready handshake. Owns the fetch PC, a small in-order fetch buffer, branch/jump redirects from EX, and a halt request. Sits between the PC logic and the IF/ID pipeline register in the 5-stage core.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset.
IMEM_DEPTH, 64, instruction memory depth in words; used only by the optional feature.
BUF_DEPTH, 2, fetch buffer entries; power of two, >= 2.

Ports:
clk  input  1  core clock, all state on rising edge.
reset  input  1  synchronous, active-high reset.
imem_addr  output  32  byte address to instruction memory; always equals fetch_pc.
imem_rdata  input  32  instruction word read combinationally at imem_addr.
imem_en  output  1  high in cycles where imem_rdata is captured (issue).
redirect_valid  input  1  EX-stage taken branch/jump this cycle.
redirect_pc  input  32  redirect target byte address.
halt_req  input  1  level; stop issuing new fetches while high.
out_valid  output  1  head buffer entry valid.
out_ready  input  1  IF/ID accepts head entry.
out_pc  output  32  byte PC of head entry.
out_instr  output  32  instruction of head entry.
fetch_fault  output  1  out-of-range fetch flag (optional feature; constant 0 when compiled out).

Behaviour:
- Interface fixed: one clock clk; reset synchronous, active-high, named reset.
- States: BOOT, RUN, HALTED, FAULT (FAULT only reachable with feature).
- Reset (synchronous, at any time incl. mid-operation): state=BOOT, fetch_pc=RESET_PC, buffer count=0, out_valid=0, out_pc=0, out_instr=0, fetch_fault=0, imem_en=0.
- BOOT: one cycle, no issue; -> HALTED if halt_req else RUN.
- RUN: issue = !halt_req && !redirect_valid && (count<BUF_DEPTH || pop). On issue: push {fetch_pc, imem_rdata}, fetch_pc <= fetch_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0). halt_req high -> HALTED.
- HALTED: no issue; buffer keeps draining; -> RUN when halt_req low.
- pop = out_valid && out_ready; head advances; simultaneous push+pop when full is legal, count unchanged.
- Latency: word fetched at cycle N visible on out_* at N+1 if buffer was empty.
- out_valid = (count!=0); out_pc/out_instr hold head contents, stable while out_valid && !out_ready.
- Redirect (priority over issue, pop, halt): buffer flushed (count=0, any same-cycle pop discarded), fetch_pc <= {redirect_pc[31:2],2'b00}; no issue that cycle; first redirected instr on out_* two cycles after redirect cycle. Accepted in RUN and HALTED, ignored in BOOT and FAULT.
- out_pc/out_instr when out_valid=0: hold last values (don't-care for checkers).
- Order strictly preserved; no entry lost or duplicated absent redirect/reset.

Optional Feature:
Macro IMEM_BOUNDS_CHECK_EN.
- Defined: an issue attempt with fetch_pc[31:2] >= IMEM_DEPTH does not issue; state -> FAULT, fetch_fault=1 (sticky until reset), buffer drains normally, no further issue; redirects ignored.
- Undefined: no range check, fetch_pc wraps freely, FAULT unreachable, fetch_fault tied 0.

Test Plan:
- Reset release, out_ready=1, mem[i]=32'h1000_0000+i -> BOOT 1 cycle; out_pc 0,4,8,... one per cycle from cycle 2; out_instr matches.
- out_ready=0 for 5 cycles from steady stream -> buffer fills to 2, imem_en=0, fetch_pc frozen, out_* stable; release -> next pcs continue with no gap/duplicate.
- redirect_valid=1, redirect_pc=32'h0000_0042 with 2 entries buffered -> out_valid=0 next cycle, then out_pc=0x40, 0x44; flushed entries never appear.
- halt_req high 3 cycles with out_ready=1 -> buffered entries drain, no new issue, imem_en=0; release -> fetch resumes at held pc.
- reset asserted mid-stream (count=2) -> next cycle out_valid=0, fetch_pc=RESET_PC, stream restarts at 0.
- With IMEM_BOUNDS_CHECK_EN, IMEM_DEPTH=64, redirect to 0xF8 -> 0xF8, 0xFC delivered, fetch_fault=1 at attempt on 0x100, nothing further; without macro -> 0x100 fetched, fetch_fault=0.
